// File: rtl/serial_add_unit.sv
// Bit-serial adder: one full-add slice plus a carry flop, LSB first, WIDTH edges per operation.
// Operands arrive over a valid/ready handshake; sum/cout leave over a second one.
module serial_add_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   a_sh, a_sh_d;
  logic [WIDTH-1:0]   b_sh, b_sh_d;
  logic [WIDTH-1:0]   acc, acc_d;
  logic [WIDTH-1:0]   sum_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               carry, carry_d;
  logic               cout_d;
  logic               bit_s;
  logic               bit_c;

  // Single full-add slice on the current LSBs.
  assign bit_s = a_sh[0] ^ b_sh[0] ^ carry;
  assign bit_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

  // Next-state and datapath updates.
  always_comb begin
    state_d = state;
    a_sh_d  = a_sh;
    b_sh_d  = b_sh;
    acc_d   = acc;
    cnt_d   = cnt;
    carry_d = carry;
    sum_d   = sum;
    cout_d  = cout;
    case (state)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh >> 1;
        b_sh_d  = b_sh >> 1;
        acc_d   = (acc >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
        carry_d = bit_c;
        cnt_d   = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          // Last bit: publish the result so it survives the next accept's clear.
          cnt_d   = '0;
          sum_d   = acc_d;
          cout_d  = bit_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      a_sh      <= a_sh_d;
      b_sh      <= b_sh_d;
      acc       <= acc_d;
      cnt       <= cnt_d;
      carry     <= carry_d;
      sum       <= sum_d;
      cout      <= cout_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_serial_add_unit.sv
// Directed self-checking bench for serial_add_unit (WIDTH=4): latency, wrap,
// backpressure, held in_valid, mid-run reset and an exhaustive operand sweep.
module tb_serial_add_unit;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_add_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation; scramble inputs after accept; report result, latency, in_ready-low samples.
  task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                       input int stall, output logic [W-1:0] s, output logic co,
                       output int lat, output int low);
    int guard;
    guard = 0;
    in_valid = 1'b1; a = ai; b = bi; cin = ci; out_ready = 1'b0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    low = in_ready ? 0 : 1;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
      if (!in_ready) low++;
    end
    s = sum;
    co = cout;
    repeat (stall) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b vld=%b busy=%b cout=%b sum=%0d, want 1 0 0 0 0",
               in_ready, out_valid, busy, cout, sum);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] s;
    logic co;
    int lat, low;
    do_op(4'd4, 4'd1, 1'b0, 0, s, co, lat, low);
    n_tests++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d edges, want 4", lat);
    end
    n_tests++;
    if ({co, s} !== 5'd5) begin
      n_fail++;
      $display("FAIL basic_sum: got cout=%b sum=%0d, want cout=0 sum=5", co, s);
    end
    n_tests++;
    if (low !== 5) begin
      n_fail++;
      $display("FAIL basic_in_ready_low: got %0d cycles, want 5", low);
    end
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_return_idle: got rdy=%b vld=%b busy=%b, want 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] s;
    logic co;
    int lat, low;
    do_op(4'd15, 4'd1, 1'b0, 0, s, co, lat, low);
    n_tests++;
    if ({co, s} !== 5'b1_0000) begin
      n_fail++;
      $display("FAIL wrap_15_1: got cout=%b sum=%0d, want cout=1 sum=0", co, s);
    end
    do_op(4'd9, 4'd7, 1'b1, 0, s, co, lat, low);
    n_tests++;
    if ({co, s} !== 5'b1_0001) begin
      n_fail++;
      $display("FAIL wrap_9_7_1: got cout=%b sum=%0d, want cout=1 sum=1", co, s);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    in_valid = 1'b1; a = 4'd3; b = 4'd2; cin = 1'b0; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    n_tests++;
    if (out_valid !== 1'b1 || sum !== 4'd5 || lat !== 4) begin
      n_fail++;
      $display("FAIL bp_first_valid: got vld=%b sum=%0d lat=%0d, want 1 5 4", out_valid, sum, lat);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 4'd5 || cout !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got vld=%b rdy=%b sum=%0d cout=%b busy=%b, want 1 0 5 0 1",
                 i, out_valid, in_ready, sum, cout, busy);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 4'd5) begin
      n_fail++;
      $display("FAIL bp_release: got rdy=%b vld=%b sum=%0d, want 1 0 5", in_ready, out_valid, sum);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    in_valid = 1'b1; a = 4'd1; b = 4'd1; cin = 1'b0; out_ready = 1'b1;
    tick();
    a = 4'd7; b = 4'd7;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    n_tests++;
    if ({cout, sum} !== 5'd2 || lat !== 4) begin
      n_fail++;
      $display("FAIL b2b_first: got cout=%b sum=%0d lat=%0d, want 0 2 4", cout, sum, lat);
    end
    tick();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: got rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_accept: got rdy=%b busy=%b, want 0 1", in_ready, busy);
    end
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    n_tests++;
    if ({cout, sum} !== 5'd14 || lat !== 4) begin
      n_fail++;
      $display("FAIL b2b_second: got cout=%b sum=%0d lat=%0d, want 0 14 4", cout, sum, lat);
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] s;
    logic co;
    int lat, low;
    bit stray;
    in_valid = 1'b1; a = 4'd6; b = 4'd5; cin = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL midrun_reset_values: got rdy=%b vld=%b busy=%b cout=%b sum=%0d, want 1 0 0 0 0",
               in_ready, out_valid, busy, cout, sum);
    end
    tick();
    rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stray = 1'b1;
    end
    n_tests++;
    if (stray !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_no_stray: got stray=%b, want 0", stray);
    end
    do_op(4'd2, 4'd2, 1'b0, 0, s, co, lat, low);
    n_tests++;
    if ({co, s} !== 5'd4 || lat !== 4) begin
      n_fail++;
      $display("FAIL midrun_followup: got cout=%b sum=%0d lat=%0d, want 0 4 4", co, s, lat);
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] s;
    logic co;
    int lat, low;
    logic [W:0] exp;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          exp = (W+1)'(ia) + (W+1)'(ib) + (W+1)'(ic);
          do_op(W'(ia), W'(ib), 1'(ic), int'($urandom_range(0, 3)), s, co, lat, low);
          n_tests++;
          if ({co, s} !== exp || lat !== 4) begin
            n_fail++;
            $display("FAIL sweep_%0d_%0d_%0d: got {cout,sum}=%0d lat=%0d, want %0d lat=4",
                     ia, ib, ic, {co, s}, lat, exp);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_unit.md
Name: serial_add_unit

Overview:
- Bit-serial adder that adds WIDTH-bit operand pairs one bit per clock, LSB first, through a single 1-bit full-add slice plus a carry flop.
- Sits behind the per-bit adder array as its area-reduced sequential counterpart.
- Accepts operand pairs from an upstream producer over a valid/ready handshake.
- Delivers sum and carry-out downstream over a second valid/ready handshake.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion is synchronous to clk
- in_valid  input  1  operand pair a/b/cin valid
- in_ready  output  1  block can accept an operand pair
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in for the addition
- out_valid  output  1  sum/cout valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH
- cout  output  1  bit WIDTH of a + b + cin
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, busy=0, state=IDLE, counter=0, carry=0, shift registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a and b into shift registers, set carry=cin, clear counter and sum register, go to RUN.
  - in_valid=0: stay in IDLE.
- RUN:
  - in_ready=0.
  - Each edge: s = a_sh[0] ^ b_sh[0] ^ carry; carry <= majority(a_sh[0], b_sh[0], carry).
  - Shift a_sh and b_sh right by 1; shift s into the MSB of the sum register, which shifts right.
  - counter increments each edge.
  - On the edge where counter reaches WIDTH-1, go to DONE.
  - Exactly WIDTH RUN edges; after them the sum register holds the full result LSB-aligned and the carry flop holds cout.
- DONE:
  - out_valid=1; sum and cout are stable and held.
  - On an edge with out_ready=1, go to IDLE (out_valid=0, in_ready=1 the next cycle).
  - out_ready=0: hold indefinitely with no change to sum/cout.
- Latency: out_valid rises exactly WIDTH clock edges after the accepting edge.
- Throughput: one result per WIDTH+2 cycles minimum; no overlap of accept and deliver.
- in_valid while in RUN or DONE: ignored and not latched. Upstream must hold it until in_ready is seen.
- Changes on a/b/cin after the accept edge do not affect the result.
- sum and cout outputs are registered and keep their last value after DONE->IDLE until the next result completes. Only out_valid qualifies them.
- WIDTH=1: a single RUN edge, then DONE.
- Reset mid-RUN or mid-DONE: in-flight operation discarded, no output produced, all outputs at reset values while rst_n=0.
- First accept is possible on the first edge after rst_n deasserts.
- No X propagation from unused inputs: a/b/cin are sampled only on the accepting edge.

Test Plan:
- WIDTH=4, a=4, b=1, cin=0, out_ready=1 -> out_valid high 4 edges after accept, sum=5, cout=0; in_ready low for 5 cycles.
- a=15, b=1, cin=0 -> sum=0, cout=1 (wrap-around); then a=9, b=7, cin=1 -> sum=1, cout=1.
- Backpressure: a=3, b=2, cin=0, out_ready=0 for 10 cycles after out_valid -> sum=5 held, out_valid stays 1, in_ready stays 0; raise out_ready -> in_ready returns the next cycle.
- in_valid held high with a=7, b=7 throughout RUN/DONE of a prior 1+1 op -> first result sum=2; the second op is accepted only in the next IDLE and gives sum=14, cout=0.
- Assert rst_n=0 at RUN edge 2 of a=6, b=5 -> out_valid=0, in_ready=1 after release, no stray result; a subsequent a=2, b=2 gives sum=4.
- Exhaustive sweep, WIDTH=4: all 512 a/b/cin combinations with random out_ready stalls -> {cout,sum} == a+b+cin every time.
